// File: rtl/connect4_pkg.sv
// rtl/connect4_pkg.sv - shared key codes, coordinate width and dropper state enum
package connect4_pkg;

    localparam int COORD_W = 10;

    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_DROP  = 8'h2C;

    typedef enum logic [1:0] {
        IDLE,
        FALL,
        LAND
    } state_t;

endpackage

// File: rtl/piece_dropper_if.sv
// rtl/piece_dropper_if.sv - board/keyboard-facing signal bundle of the piece dropper
interface piece_dropper_if #(
    parameter int NUM_COLS = 7,
    parameter int NUM_ROWS = 6
);
    import connect4_pkg::*;

    localparam int COL_W = $clog2(NUM_COLS);
    localparam int ROW_W = $clog2(NUM_ROWS);

    logic [7:0]         keycode;
    logic [NUM_COLS-1:0] col_full;
    logic [ROW_W-1:0]   land_row;
    logic [COORD_W-1:0] PieceX;
    logic [COORD_W-1:0] PieceY;
    logic [COL_W-1:0]   cur_col;
    logic               busy;
    logic               drop_done;
    logic               player;

    modport master (
        output keycode, col_full, land_row,
        input  PieceX, PieceY, cur_col, busy, drop_done, player
    );

    modport slave (
        input  keycode, col_full, land_row,
        output PieceX, PieceY, cur_col, busy, drop_done, player
    );

endinterface

// File: rtl/piece_dropper_key_edge_detect.sv
// rtl/piece_dropper_key_edge_detect.sv - one-frame pulses on a new LEFT/RIGHT/DROP keycode
module key_edge_detect
    import connect4_pkg::*;
(
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    output logic       left_p,
    output logic       right_p,
    output logic       drop_p
);

    logic [7:0] prev_key_q;
    logic [7:0] prev_key_d;
    logic       key_new;

    always_comb begin
        prev_key_d = keycode;
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            prev_key_q <= '0;
        end else begin
            prev_key_q <= prev_key_d;
        end
    end

    assign key_new = (keycode != prev_key_q);
    assign left_p  = key_new && (keycode == KEY_LEFT);
    assign right_p = key_new && (keycode == KEY_RIGHT);
    assign drop_p  = key_new && (keycode == KEY_DROP);

endmodule

// File: rtl/piece_dropper.sv
// rtl/piece_dropper.sv - hover piece column select and per-frame drop animation
module piece_dropper
    import connect4_pkg::*;
#(
    parameter int NUM_COLS  = 7,
    parameter int NUM_ROWS  = 6,
    parameter int ORIGIN_X  = 150,
    parameter int ORIGIN_Y  = 75,
    parameter int CELL_W    = 60,
    parameter int CELL_H    = 60,
    parameter int DROP_STEP = 4,
    parameter int WRAP      = 1,
    parameter int START_COL = 0
) (
    input  logic            frame_clk,
    input  logic            Reset,
    piece_dropper_if.slave  pd
);

    localparam int COL_W = $clog2(NUM_COLS);

    localparam logic [COL_W-1:0]   LAST_COL  = COL_W'(NUM_COLS - 1);
    localparam logic [COL_W-1:0]   COL_RST   = COL_W'(START_COL);
    localparam logic [COORD_W-1:0] X0        = COORD_W'(ORIGIN_X);
    localparam logic [COORD_W-1:0] Y0        = COORD_W'(ORIGIN_Y);
    localparam logic [COORD_W-1:0] CW        = COORD_W'(CELL_W);
    localparam logic [COORD_W-1:0] CH        = COORD_W'(CELL_H);
    localparam logic [COORD_W-1:0] STEP      = COORD_W'(DROP_STEP);
    localparam logic [COORD_W-1:0] X_RST     = COORD_W'(ORIGIN_X + START_COL * CELL_W);

    if (ORIGIN_Y + NUM_ROWS * CELL_H > 1023) begin : g_bad_y
        $error("piece_dropper: board bottom exceeds 10-bit Y range");
    end
    if (ORIGIN_X + (NUM_COLS - 1) * CELL_W > 1023) begin : g_bad_x
        $error("piece_dropper: last column exceeds 10-bit X range");
    end
    if (DROP_STEP < 1 || DROP_STEP > CELL_H) begin : g_bad_step
        $error("piece_dropper: DROP_STEP must be within 1..CELL_H");
    end

    logic left_p, right_p, drop_p;

    key_edge_detect u_keys (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .keycode   (pd.keycode),
        .left_p    (left_p),
        .right_p   (right_p),
        .drop_p    (drop_p)
    );

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [COORD_W-1:0] target_q, target_d;
    logic               busy_q, busy_d;
    logic               drop_done_q, drop_done_d;
    logic               player_q, player_d;
    logic [COORD_W:0]   fall_sum;

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        y_d         = y_q;
        target_d    = target_q;
        busy_d      = busy_q;
        drop_done_d = drop_done_q;
        player_d    = player_q;
        fall_sum    = {1'b0, y_q} + {1'b0, STEP};

        case (state_q)
            IDLE: begin
                if (left_p) begin
                    if (col_q == '0) begin
                        col_d = (WRAP != 0) ? LAST_COL : '0;
                    end else begin
                        col_d = col_q - 1'b1;
                    end
                end else if (right_p) begin
                    if (col_q == LAST_COL) begin
                        col_d = (WRAP != 0) ? '0 : LAST_COL;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end else if (drop_p && !pd.col_full[col_q]) begin
                    target_d = Y0 + (COORD_W'(pd.land_row) + 1'b1) * CH;
                    state_d  = FALL;
                    busy_d   = 1'b1;
                end
            end
            FALL: begin
                // Overshoot of the last partial step is clamped onto the target
                if (fall_sum >= {1'b0, target_q}) begin
                    y_d     = target_q;
                    state_d = LAND;
                end else begin
                    y_d = fall_sum[COORD_W-1:0];
                end
            end
            LAND: begin
                // The piece rests on its target one frame before the pulse, then one frame with it
                if (!drop_done_q) begin
                    drop_done_d = 1'b1;
                end else begin
                    drop_done_d = 1'b0;
                    busy_d      = 1'b0;
                    y_d         = Y0;
                    player_d    = ~player_q;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        x_d = X0 + COORD_W'(col_d) * CW;
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            col_q       <= COL_RST;
            x_q         <= X_RST;
            y_q         <= Y0;
            target_q    <= Y0;
            busy_q      <= 1'b0;
            drop_done_q <= 1'b0;
            player_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            x_q         <= x_d;
            y_q         <= y_d;
            target_q    <= target_d;
            busy_q      <= busy_d;
            drop_done_q <= drop_done_d;
            player_q    <= player_d;
        end
    end

    assign pd.PieceX    = x_q;
    assign pd.PieceY    = y_q;
    assign pd.cur_col   = col_q;
    assign pd.busy      = busy_q;
    assign pd.drop_done = drop_done_q;
    assign pd.player    = player_q;

endmodule

// File: tb/tb_piece_dropper.sv
// tb/tb_piece_dropper.sv - directed bench for piece_dropper (wrapping and saturating instances)
module tb_piece_dropper;

    logic frame_clk = 1'b0;
    logic Reset;

    always #5 frame_clk = ~frame_clk;

    piece_dropper_if #(.NUM_COLS(7), .NUM_ROWS(6)) a_if ();
    piece_dropper_if #(.NUM_COLS(7), .NUM_ROWS(6)) b_if ();

    piece_dropper dut_a (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .pd        (a_if.slave)
    );

    piece_dropper #(.WRAP(0), .DROP_STEP(7)) dut_b (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .pd        (b_if.slave)
    );

    int errors = 0;
    int checks = 0;
    int a_dd   = 0;
    int b_dd   = 0;

    always @(posedge frame_clk) begin
        if (a_if.drop_done === 1'b1) a_dd++;
        if (b_if.drop_done === 1'b1) b_dd++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge frame_clk);
            #1;
        end
    endtask

    task automatic set_key(input logic [7:0] k);
        a_if.keycode = k;
        b_if.keycode = k;
    endtask

    task automatic press(input logic [7:0] k);
        set_key(8'h00);
        step(1);
        set_key(k);
        step(1);
    endtask

    initial begin
        Reset         = 1'b1;
        set_key(8'h00);
        a_if.col_full = 7'b0;
        a_if.land_row = 3'd5;
        b_if.col_full = 7'b0;
        b_if.land_row = 3'd0;
        #2;
        chk("rst_a_x", a_if.PieceX, 150);
        chk("rst_a_y", a_if.PieceY, 75);
        chk("rst_a_col", a_if.cur_col, 0);
        chk("rst_a_busy", a_if.busy, 0);
        chk("rst_a_player", a_if.player, 0);
        chk("rst_a_dd", a_if.drop_done, 0);
        chk("rst_b_x", b_if.PieceX, 150);
        Reset = 1'b0;

        set_key(8'h4F);
        step(1);
        chk("right1_col", a_if.cur_col, 1);
        chk("right1_x", a_if.PieceX, 210);
        step(4);
        chk("hold_col", a_if.cur_col, 1);
        chk("hold_x", a_if.PieceX, 210);
        chk("hold_b_col", b_if.cur_col, 1);

        press(8'h4F);
        chk("right2_col", a_if.cur_col, 2);
        chk("right2_x", a_if.PieceX, 270);
        chk("right2_b_x", b_if.PieceX, 270);

        press(8'h50);
        press(8'h50);
        chk("left_to0_col", a_if.cur_col, 0);
        chk("left_to0_b_col", b_if.cur_col, 0);
        press(8'h50);
        chk("wrap_left_col", a_if.cur_col, 6);
        chk("wrap_left_x", a_if.PieceX, 510);
        chk("sat_left_col", b_if.cur_col, 0);
        chk("sat_left_x", b_if.PieceX, 150);
        press(8'h4F);
        chk("wrap_right_col", a_if.cur_col, 0);
        chk("wrap_right_x", a_if.PieceX, 150);
        chk("b_right_col", b_if.cur_col, 1);

        press(8'h2C);
        chk("drop_a_busy", a_if.busy, 1);
        chk("drop_a_y", a_if.PieceY, 75);
        chk("drop_b_busy", b_if.busy, 1);

        for (int i = 1; i <= 90; i++) begin
            set_key((i == 1) ? 8'h50 : (i == 2) ? 8'h4F : 8'h2C);
            step(1);
            chk($sformatf("fall_a_y%0d", i), a_if.PieceY, 75 + 4 * i);
            chk($sformatf("fall_a_busy%0d", i), a_if.busy, 1);
            chk($sformatf("fall_a_dd%0d", i), a_if.drop_done, 0);
            chk($sformatf("fall_a_x%0d", i), a_if.PieceX, 150);
            chk($sformatf("fall_b_col%0d", i), b_if.cur_col, 1);
            if (i <= 8) begin
                chk($sformatf("fall_b_y%0d", i), b_if.PieceY, 75 + 7 * i);
                chk($sformatf("fall_b_busy%0d", i), b_if.busy, 1);
            end else if (i == 9) begin
                chk("clamp_b_y", b_if.PieceY, 135);
                chk("clamp_b_dd", b_if.drop_done, 0);
            end else if (i == 10) begin
                chk("land_b_dd", b_if.drop_done, 1);
                chk("land_b_y", b_if.PieceY, 135);
            end else begin
                chk($sformatf("idle_b_y%0d", i), b_if.PieceY, 75);
                chk($sformatf("idle_b_busy%0d", i), b_if.busy, 0);
                chk($sformatf("idle_b_player%0d", i), b_if.player, 1);
            end
        end

        step(1);
        chk("land_a_dd", a_if.drop_done, 1);
        chk("land_a_y", a_if.PieceY, 435);
        chk("land_a_busy", a_if.busy, 1);
        step(1);
        chk("exit_a_y", a_if.PieceY, 75);
        chk("exit_a_player", a_if.player, 1);
        chk("exit_a_busy", a_if.busy, 0);
        chk("exit_a_dd", a_if.drop_done, 0);
        chk("exit_a_col", a_if.cur_col, 0);
        step(1);
        chk("held_drop_busy", a_if.busy, 0);
        chk("a_dd_count", a_dd, 1);
        chk("b_dd_count", b_dd, 1);

        b_if.col_full = 7'b1111111;
        a_if.col_full = 7'b0001000;
        press(8'h4F);
        press(8'h4F);
        press(8'h4F);
        chk("to3_col", a_if.cur_col, 3);
        chk("to3_x", a_if.PieceX, 330);
        press(8'h2C);
        chk("full_busy", a_if.busy, 0);
        chk("full_y", a_if.PieceY, 75);
        step(3);
        chk("full_busy_later", a_if.busy, 0);
        chk("full_dd_count", a_dd, 1);
        chk("full_b_busy", b_if.busy, 0);

        a_if.col_full = 7'b0;
        press(8'h2C);
        chk("mid_drop_busy", a_if.busy, 1);
        step(5);
        chk("mid_drop_y", a_if.PieceY, 95);
        set_key(8'h00);
        Reset = 1'b1;
        #1;
        chk("async_rst_x", a_if.PieceX, 150);
        chk("async_rst_y", a_if.PieceY, 75);
        chk("async_rst_col", a_if.cur_col, 0);
        chk("async_rst_busy", a_if.busy, 0);
        chk("async_rst_player", a_if.player, 0);
        step(2);
        Reset = 1'b0;
        step(3);
        chk("post_rst_busy", a_if.busy, 0);
        chk("post_rst_y", a_if.PieceY, 75);
        chk("post_rst_dd_count", a_dd, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
